// File: rtl/ps2_key_event_sequencer.sv
// PS/2 Set 2 key event sequencer: decodes the E0/F0 prefixes, suppresses
// typematic repeats with a held-key bitmap and queues events in a FWFT FIFO.
//
// Ports:
//   Clk, reset        clock, asynchronous active-high reset
//   byteIn/byteValid  scan-code byte stream from the PS/2 receiver
//   evReady           consumer accepts the head event
//   evValid/evCode/evExt/evPress  head event of the queue
//   anyHeld           at least one key is currently held
//   overflow          sticky, an event was dropped on a full queue
//   dropCount         saturating count of dropped events
//   protoErr          sticky, illegal prefix sequence or prefix timeout
module ps2_key_event_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [7:0] byteIn,
    input  logic       byteValid,
    input  logic       evReady,
    output logic       evValid,
    output logic [7:0] evCode,
    output logic       evExt,
    output logic       evPress,
    output logic       anyHeld,
    output logic       overflow,
    output logic [7:0] dropCount,
    output logic       protoErr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_set;
    logic          ev_fire;
    logic          ev_ext;
    logic          ev_press;
    logic [7:0]    ev_code;
    logic          is_e0, is_f0;

    logic [511:0]  held_q, held_d;
    logic [8:0]    held_idx;
    logic          push;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full, pop, wr_en, drop;
    logic [9:0]    head;

    logic          proto_q, ovf_q;
    logic [7:0]    drop_q;

    // Prefix FSM. The timeout counter only runs while a prefix is pending
    // and restarts from zero on every accepted byte.
    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        err_set  = 1'b0;
        ev_fire  = 1'b0;
        ev_ext   = 1'b0;
        ev_press = 1'b1;
        ev_code  = byteIn;
        is_e0    = (byteIn == 8'hE0);
        is_f0    = (byteIn == 8'hF0);
        if (byteValid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_e0) begin
                        state_d = S_EXT;
                    end else if (is_f0) begin
                        state_d = S_BRK;
                    end else begin
                        ev_fire = 1'b1;
                    end
                end
                S_EXT: begin
                    if (is_f0) begin
                        state_d = S_EXT_BRK;
                    end else if (is_e0) begin
                        state_d = S_IDLE;
                        err_set = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (is_e0 || is_f0) begin
                        err_set = 1'b1;
                    end else begin
                        ev_fire  = 1'b1;
                        ev_press = 1'b0;
                    end
                end
                S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (is_e0 || is_f0) begin
                        err_set = 1'b1;
                    end else begin
                        ev_fire  = 1'b1;
                        ev_ext   = 1'b1;
                        ev_press = 1'b0;
                    end
                end
            endcase
        end else if (state_q != S_IDLE) begin
            // A byte on the expiry cycle wins, so expiry is only checked here.
            if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                err_set = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // A make pushes only when the key was up, a break only when it was down;
    // the bitmap tracks the key even if the queue drops the event.
    always_comb begin
        held_idx = {ev_ext, ev_code};
        held_d   = held_q;
        push     = ev_fire && (ev_press ^ held_q[held_idx]);
        if (push) begin
            held_d[held_idx] = ev_press;
        end
    end

    assign full  = (cnt_q == DEPTH_C);
    assign pop   = evValid && evReady;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            held_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            proto_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            if (wr_en) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (err_set) begin
                proto_q <= 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= {ev_ext, ev_press, ev_code};
        end
    end

    assign head      = mem_q[rd_q];
    assign evValid   = (cnt_q != '0);
    assign evCode    = evValid ? head[7:0] : 8'h00;
    assign evPress   = evValid ? head[8] : 1'b0;
    assign evExt     = evValid ? head[9] : 1'b0;
    assign anyHeld   = |held_q;
    assign overflow  = ovf_q;
    assign dropCount = drop_q;
    assign protoErr  = proto_q;

endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// Directed self-checking bench for ps2_key_event_sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ps2_key_event_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byteIn = 8'h00;
    logic       byteValid = 1'b0;
    logic       evReady = 1'b0;
    logic       evValid;
    logic [7:0] evCode;
    logic       evExt;
    logic       evPress;
    logic       anyHeld;
    logic       overflow;
    logic [7:0] dropCount;
    logic       protoErr;

    int compared = 0;
    int mismatched = 0;

    ps2_key_event_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .byteIn(byteIn),
        .byteValid(byteValid),
        .evReady(evReady),
        .evValid(evValid),
        .evCode(evCode),
        .evExt(evExt),
        .evPress(evPress),
        .anyHeld(anyHeld),
        .overflow(overflow),
        .dropCount(dropCount),
        .protoErr(protoErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Head event as {valid, ext, code, press}.
    task automatic chk_ev(input string tag, input logic ext,
                          input logic [7:0] code, input logic press);
        chk(tag, {21'd0, evValid, evExt, evCode, evPress},
            {21'd0, 1'b1, ext, code, press});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge Clk);
        byteIn    = b;
        byteValid = 1'b1;
        @(negedge Clk);
        byteValid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {20'd0, evValid, evCode, evExt, evPress,
                  anyHeld, overflow, dropCount, protoErr}, 32'd0);
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        drain_exp[0] = 8'h16; drain_exp[1] = 8'h1D;
        drain_exp[2] = 8'h1E; drain_exp[3] = 8'h24;
        drain_exp[4] = 8'h25; drain_exp[5] = 8'h2C;
        drain_exp[6] = 8'h2D; drain_exp[7] = 8'h35;

        repeat (2) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk_all_zero("reset_state");

        // Typematic suppression
        evReady = 1'b1;
        send(8'h1C);
        chk_ev("make_1C", 1'b0, 8'h1C, 1'b1);
        chk("held_after_make", 32'(anyHeld), 32'd1);
        send(8'h1C);
        chk("repeat1_no_ev", 32'(evValid), 32'd0);
        send(8'h1C);
        chk("repeat2_no_ev", 32'(evValid), 32'd0);
        send(8'hF0);
        chk("f0_no_ev", 32'(evValid), 32'd0);
        send(8'h1C);
        chk_ev("break_1C", 1'b0, 8'h1C, 1'b0);
        chk("held_after_break", 32'(anyHeld), 32'd0);
        @(negedge Clk);
        chk("popped_empty", 32'(evValid), 32'd0);

        // Extended make and break
        send(8'hE0);
        send(8'h75);
        chk_ev("ext_make_75", 1'b1, 8'h75, 1'b1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk_ev("ext_break_75", 1'b1, 8'h75, 1'b0);
        chk("no_proto_err", 32'(protoErr), 32'd0);
        chk("ext_none_held", 32'(anyHeld), 32'd0);

        // Overflow with consumer stalled
        @(negedge Clk);
        evReady = 1'b0;
        send(8'h15); send(8'h16); send(8'h1D);
        send(8'h1E); send(8'h24); send(8'h25);
        send(8'h2C); send(8'h2D);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        send(8'h34);
        chk("ovf_valid", 32'(evValid), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count1", 32'(dropCount), 32'd1);
        chk_ev("ovf_head", 1'b0, 8'h15, 1'b1);
        chk_ev("head_stable", 1'b0, 8'h15, 1'b1);

        // Push and pop on the same cycle while full
        byteIn    = 8'h35;
        byteValid = 1'b1;
        evReady   = 1'b1;
        @(negedge Clk);
        byteValid = 1'b0;
        evReady   = 1'b0;
        chk("pushpop_no_drop", 32'(dropCount), 32'd1);
        chk_ev("pushpop_head", 1'b0, 8'h16, 1'b1);
        // Still full: one more make is dropped
        send(8'h36);
        chk("still_full_drop", 32'(dropCount), 32'd2);

        evReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_ev($sformatf("drain_%0d", i), 1'b0, drain_exp[i], 1'b1);
            @(negedge Clk);
        end
        chk("drained_empty", 32'(evValid), 32'd0);
        chk("drain_held", 32'(anyHeld), 32'd1);

        // Byte on the expiry cycle wins over the timeout
        send(8'hE0);
        repeat (TMO - 2) @(negedge Clk);
        send(8'h75);
        chk_ev("tmo_prio_ev", 1'b1, 8'h75, 1'b1);
        chk("tmo_prio_no_err", 32'(protoErr), 32'd0);

        // Timeout after a lone E0
        send(8'hE0);
        repeat (TMO - 1) @(negedge Clk);
        chk("tmo_not_yet", 32'(protoErr), 32'd0);
        @(negedge Clk);
        chk("tmo_err", 32'(protoErr), 32'd1);
        chk("tmo_no_ev", 32'(evValid), 32'd0);
        send(8'h75);
        chk_ev("after_tmo_75", 1'b0, 8'h75, 1'b1);

        // Illegal F0 E0
        pulse_reset();
        chk("rst_clears_err", 32'(protoErr), 32'd0);
        send(8'hF0);
        send(8'hE0);
        chk("f0e0_err", 32'(protoErr), 32'd1);
        chk("f0e0_no_ev", 32'(evValid), 32'd0);
        send(8'h1C);
        chk_ev("f0e0_then_make", 1'b0, 8'h1C, 1'b1);

        // Reset with queued events and a pending prefix
        pulse_reset();
        @(negedge Clk);
        evReady = 1'b0;
        send(8'h1C); send(8'h1D); send(8'h1E);
        send(8'hF0);
        chk("pre_rst_held", 32'(anyHeld), 32'd1);
        pulse_reset();
        chk_all_zero("mid_seq_reset");
        evReady = 1'b1;
        send(8'h1C);
        chk_ev("post_rst_make", 1'b0, 8'h1C, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_sequencer.md
# ps2_key_event_sequencer

Sits between the PS/2 byte receiver and the game logic. Consumes the completed scan-code byte stream (Set 2), decodes the E0 extended and F0 break prefixes with a state machine, and suppresses typematic repeats using a held-key bitmap. Queues clean press/release events in a FIFO with a valid/ready handshake, so consumers never see repeats or lose events to a single-register overwrite.

## Interface
- FIFO_DEPTH, 8, event queue depth; power of two, ≥2
- TIMEOUT_CYCLES, 50000, Clk cycles allowed between a prefix byte and its following byte
- Clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- byteIn  in  8  completed scan-code byte from the PS/2 receiver
- byteValid  in  1  one-cycle strobe; byteIn is valid this cycle; no backpressure
- evReady  in  1  consumer accepts head event this cycle
- evValid  out  1  FIFO not empty
- evCode  out  8  head event scan code
- evExt  out  1  head event carried an E0 prefix
- evPress  out  1  1 = make (press), 0 = break (release)
- anyHeld  out  1  OR of the held bitmap
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- dropCount  out  8  dropped events, saturates at 255
- protoErr  out  1  sticky; illegal prefix sequence or timeout seen

## Operation
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Acts only on cycles with byteValid=1.
- IDLE: E0→EXT; F0→BRK; any other byte c → make(ext=0,c), stay IDLE.
- EXT: F0→EXT_BRK; E0→IDLE with protoErr; c → make(1,c), →IDLE.
- BRK: c → break(0,c), →IDLE; E0 or F0 → IDLE with protoErr, no event.
- EXT_BRK: c → break(1,c), →IDLE; E0 or F0 → IDLE with protoErr, no event.
- Timeout: in any non-IDLE state, a cycle counter counts from the last accepted byte. On reaching TIMEOUT_CYCLES with no new byte, the FSM goes to IDLE, sets protoErr, and emits no event. The counter is held at 0 in IDLE.
- Held bitmap: 512 bits indexed {ext,code}.
  - make with bit clear: set the bit and push the event.
  - make with bit set: typematic repeat; no push, no change.
  - break with bit set: clear the bit and push the event.
  - break with bit clear: no push.
- The bitmap updates even when a push is dropped.
- FIFO: first-word-fall-through. The head drives evCode/evExt/evPress. A pop occurs on evValid && evReady.
- Push when full and no pop that cycle: event dropped, overflow set, dropCount incremented (saturating).
- Push and pop in the same cycle when full: both occur, nothing is dropped.
- Push and pop in the same cycle when empty: the push lands and evValid rises next cycle. There is no bypass.
- Pointers wrap modulo FIFO_DEPTH. A count register of width log2(FIFO_DEPTH)+1 distinguishes full from empty.

## Timing
- Reset values: FSM=IDLE; FIFO empty; evValid=0, evCode=0, evExt=0, evPress=0; held bitmap=0, anyHeld=0; overflow=0, dropCount=0, protoErr=0; timeout counter=0.
- Reset mid-sequence (e.g. after F0) discards the pending prefix and all queued events.
- byteValid at cycle n: FSM, bitmap and FIFO write all update at the end of cycle n.
- The event is visible at cycle n+1 (evValid=1 if the FIFO was empty). anyHeld updates at n+1.
- Pop at cycle n: the next entry, or evValid=0, is visible at n+1.
- Head outputs are stable while evValid=1 and evReady=0.
- Timeout fires on the edge where the counter reaches TIMEOUT_CYCLES. A byteValid on that same cycle takes priority: the byte is processed and the timeout is ignored.

## Test plan
- evReady=1. Bytes 1C, 1C, 1C, F0, 1C → exactly two events: {0,1C,1} then {0,1C,0}. anyHeld goes 1 then 0.
- Bytes E0 75, then E0 F0 75 → {1,75,1}, {1,75,0}. FSM back in IDLE. protoErr=0.
- evReady=0, FIFO_DEPTH=8. Makes 15,16,1D,1E,24,25,2C,2D,34 → evValid=1, overflow=1, dropCount=1. Then evReady=1 drains the 8 events in order 15…2D; anyHeld stays 1.
- FIFO full; a make strobed on the same cycle as a pop → no drop, dropCount unchanged, count stays 8.
- E0 then idle for TIMEOUT_CYCLES → protoErr=1, FSM IDLE. Next byte 75 → {0,75,1}. Separately, F0 then E0 → protoErr=1, no event.
- 3 events queued, then F0, then reset pulse → all outputs zero, bitmap cleared. Next byte 1C → {0,1C,1} at n+1.
